// File: rtl/wm_buzzer_seq.sv
// Pattern buzzer: square-wave tone gated into ON/OFF beep phases, driven by the
// shared tick strobe. Supports single beep, N-beep burst and continuous alarm.
module wm_buzzer_seq #(
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int TONE_DIV  = 1,
  parameter int CNT_W     = 4,
  parameter int TICK_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic             buzStart,
  input  logic             buzStop,
  input  logic [1:0]       buzMode,
  input  logic [CNT_W-1:0] buzCount,
  output logic             buzOut,
  output logic             buzBusy,
  output logic             buzDone
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_CONT   = 2'b10;

  localparam logic [TICK_W-1:0] ON_LAST   = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST  = TICK_W'(OFF_TICKS - 1);
  localparam logic [TICK_W-1:0] TONE_LAST = TICK_W'(TONE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [CNT_W-1:0]  BEEP_ONE  = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  beeps_left_q, beeps_left_d;
  logic [TICK_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [TICK_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              buz_out_q, buz_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the block infers a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    beeps_left_d = beeps_left_q;
    phase_cnt_d  = phase_cnt_q;
    tone_cnt_d   = tone_cnt_q;
    buz_out_d    = buz_out_q;
    done_d       = 1'b0;

    // Commands outrank tick processing; stop outranks start.
    if (buzStop) begin
      state_d      = ST_IDLE;
      mode_d       = MODE_SINGLE;
      beeps_left_d = '0;
      phase_cnt_d  = '0;
      tone_cnt_d   = '0;
      buz_out_d    = 1'b0;
    end else if (buzStart) begin
      state_d      = ST_ON;
      mode_d       = (buzMode == 2'b11) ? MODE_SINGLE : buzMode;
      beeps_left_d = (buzMode == MODE_BURST && buzCount != '0) ? buzCount : BEEP_ONE;
      phase_cnt_d  = '0;
      tone_cnt_d   = '0;
      buz_out_d    = 1'b0;
    end else if (tick) begin
      case (state_q)
        ST_ON: begin
          if (phase_cnt_q == ON_LAST) begin
            buz_out_d   = 1'b0;
            phase_cnt_d = '0;
            tone_cnt_d  = '0;
            if (mode_q == MODE_CONT) begin
              state_d = ST_OFF;
            end else if (beeps_left_q == BEEP_ONE) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              beeps_left_d = beeps_left_q - BEEP_ONE;
              state_d      = ST_OFF;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + TICK_ONE;
            if (tone_cnt_q == TONE_LAST) begin
              buz_out_d  = ~buz_out_q;
              tone_cnt_d = '0;
            end else begin
              tone_cnt_d = tone_cnt_q + TICK_ONE;
            end
          end
        end
        ST_OFF: begin
          if (phase_cnt_q == OFF_LAST) begin
            phase_cnt_d = '0;
            tone_cnt_d  = '0;
            state_d     = ST_ON;
          end else begin
            phase_cnt_d = phase_cnt_q + TICK_ONE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_SINGLE;
      beeps_left_q <= '0;
      phase_cnt_q  <= '0;
      tone_cnt_q   <= '0;
      buz_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      beeps_left_q <= beeps_left_d;
      phase_cnt_q  <= phase_cnt_d;
      tone_cnt_q   <= tone_cnt_d;
      buz_out_q    <= buz_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign buzOut  = buz_out_q;
  assign buzBusy = busy_q;
  assign buzDone = done_q;

endmodule

// File: tb/tb_wm_buzzer_seq.sv
// Directed bench for wm_buzzer_seq: table of single/burst patterns plus
// hand-written sequences for continuous mode, restart, stop and reset.
module tb_wm_buzzer_seq;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tick;
  logic       buzStart;
  logic       buzStop;
  logic [1:0] buzMode;
  logic [3:0] buzCount;
  logic       buzOut, buzBusy, buzDone;
  logic       slow_out, slow_busy, slow_done;

  int total = 0;
  int bad   = 0;

  // Values captured right after a tick edge and one clock later.
  logic t_out, t_done, t_busy, t_done_next;
  logic s_out, s_done, s_busy;

  wm_buzzer_seq #(.ON_TICKS(4), .OFF_TICKS(2), .TONE_DIV(1), .CNT_W(4), .TICK_W(16)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .buzStart(buzStart), .buzStop(buzStop),
    .buzMode(buzMode), .buzCount(buzCount),
    .buzOut(buzOut), .buzBusy(buzBusy), .buzDone(buzDone)
  );

  wm_buzzer_seq #(.ON_TICKS(6), .OFF_TICKS(2), .TONE_DIV(2), .CNT_W(4), .TICK_W(16)) dut_slow (
    .clk(clk), .rstn(rstn), .tick(tick), .buzStart(buzStart), .buzStop(buzStop),
    .buzMode(buzMode), .buzCount(buzCount),
    .buzOut(slow_out), .buzBusy(slow_busy), .buzDone(slow_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  count;
    int          n_ticks;
    logic [31:0] pattern;  // bit i = expected buzOut after tick i+1
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One tick strobe followed by three idle clocks (tick every 4 clocks).
  task automatic do_tick();
    tick = 1'b1;
    cycle();
    t_out = buzOut; t_done = buzDone; t_busy = buzBusy;
    s_out = slow_out; s_done = slow_done; s_busy = slow_busy;
    tick = 1'b0;
    cycle();
    t_done_next = buzDone;
    cycle();
    cycle();
  endtask

  task automatic send_start(input logic [1:0] mode, input logic [3:0] count);
    buzMode  = mode;
    buzCount = count;
    buzStart = 1'b1;
    cycle();
    buzStart = 1'b0;
  endtask

  task automatic run_pattern(input string tag, input int n, input logic [31:0] pat);
    logic [31:0] p;
    p = pat;
    for (int i = 0; i < n; i++) begin
      do_tick();
      check($sformatf("%s out t%0d", tag, i + 1), {31'd0, t_out}, {31'd0, p[i]});
      check($sformatf("%s done t%0d", tag, i + 1), {31'd0, t_done}, {31'd0, (i == n - 1)});
      check($sformatf("%s busy t%0d", tag, i + 1), {31'd0, t_busy}, {31'd0, (i != n - 1)});
      check($sformatf("%s done width t%0d", tag, i + 1), {31'd0, t_done_next}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{mode: 2'b00, count: 4'd0, n_ticks: 4,  pattern: 32'h5};
    vecs[1] = '{mode: 2'b01, count: 4'd3, n_ticks: 16, pattern: 32'h5145};
    vecs[2] = '{mode: 2'b01, count: 4'd0, n_ticks: 4,  pattern: 32'h5};
    vecs[3] = '{mode: 2'b11, count: 4'd7, n_ticks: 4,  pattern: 32'h5};
    vecs[4] = '{mode: 2'b01, count: 4'd2, n_ticks: 10, pattern: 32'h145};

    rstn = 1'b0; tick = 1'b0; buzStart = 1'b0; buzStop = 1'b0;
    buzMode = 2'b00; buzCount = 4'd0;
    cycle();
    cycle();
    check("reset out", {31'd0, buzOut}, 32'd0);
    check("reset busy", {31'd0, buzBusy}, 32'd0);
    check("reset done", {31'd0, buzDone}, 32'd0);
    rstn = 1'b1;
    cycle();

    // Idle ticks must not produce output.
    do_tick();
    check("idle tick out", {31'd0, t_out}, 32'd0);
    check("idle tick busy", {31'd0, t_busy}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      send_start(vecs[v].mode, vecs[v].count);
      check($sformatf("v%0d start busy", v), {31'd0, buzBusy}, 32'd1);
      check($sformatf("v%0d start out", v), {31'd0, buzOut}, 32'd0);
      cycle();
      run_pattern($sformatf("v%0d", v), vecs[v].n_ticks, vecs[v].pattern);
    end

    // Continuous: three full ON/OFF cycles, then stop while the tone is high.
    send_start(2'b10, 4'd0);
    for (int i = 0; i < 18; i++) begin
      do_tick();
      check($sformatf("cont out t%0d", i + 1), {31'd0, t_out}, {31'd0, (i % 6 == 0 || i % 6 == 2)});
      check($sformatf("cont done t%0d", i + 1), {31'd0, t_done}, 32'd0);
      check($sformatf("cont busy t%0d", i + 1), {31'd0, t_busy}, 32'd1);
    end
    do_tick();
    check("cont 4th on out", {31'd0, t_out}, 32'd1);
    buzStop = 1'b1;
    cycle();
    buzStop = 1'b0;
    check("stop out", {31'd0, buzOut}, 32'd0);
    check("stop busy", {31'd0, buzBusy}, 32'd0);
    check("stop done", {31'd0, buzDone}, 32'd0);
    cycle();
    check("stop done after", {31'd0, buzDone}, 32'd0);

    // Restart coincident with the 2nd tick of a running burst.
    send_start(2'b01, 4'd3);
    do_tick();
    check("restart pre out", {31'd0, t_out}, 32'd1);
    tick = 1'b1;
    buzMode = 2'b01; buzCount = 4'd2; buzStart = 1'b1;
    cycle();
    tick = 1'b0; buzStart = 1'b0;
    check("restart out", {31'd0, buzOut}, 32'd0);
    check("restart busy", {31'd0, buzBusy}, 32'd1);
    check("restart done", {31'd0, buzDone}, 32'd0);
    cycle();
    run_pattern("restart", 10, 32'h145);

    // Start and stop together while busy: stop wins.
    send_start(2'b10, 4'd0);
    do_tick();
    buzStart = 1'b1; buzStop = 1'b1; buzMode = 2'b01; buzCount = 4'd2;
    cycle();
    buzStart = 1'b0; buzStop = 1'b0;
    check("start+stop busy", {31'd0, buzBusy}, 32'd0);
    check("start+stop out", {31'd0, buzOut}, 32'd0);
    do_tick();
    check("start+stop idle tick", {31'd0, t_busy}, 32'd0);
    check("start+stop idle done", {31'd0, t_done}, 32'd0);

    // Slow tone (TONE_DIV=2, ON_TICKS=6) on the second instance.
    send_start(2'b00, 4'd0);
    for (int i = 0; i < 6; i++) begin
      do_tick();
      check($sformatf("slow out t%0d", i + 1), {31'd0, s_out}, {31'd0, (i == 1 || i == 2)});
      check($sformatf("slow done t%0d", i + 1), {31'd0, s_done}, {31'd0, (i == 5)});
      check($sformatf("slow busy t%0d", i + 1), {31'd0, s_busy}, {31'd0, (i != 5)});
    end

    // Reset asserted mid-ON with the slow tone high.
    send_start(2'b00, 4'd0);
    do_tick();
    do_tick();
    check("pre-reset slow out", {31'd0, slow_out}, 32'd1);
    check("pre-reset slow busy", {31'd0, slow_busy}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async reset slow out", {31'd0, slow_out}, 32'd0);
    check("async reset slow busy", {31'd0, slow_busy}, 32'd0);
    check("async reset slow done", {31'd0, slow_done}, 32'd0);
    check("async reset out", {31'd0, buzOut}, 32'd0);
    check("async reset busy", {31'd0, buzBusy}, 32'd0);
    cycle();
    rstn = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wm_buzzer_seq.md
Name: wm_buzzer_seq

Overview:
Parametrised pattern buzzer for the washing-machine controller. It generates a square-wave tone gated into repeated ON/OFF beep phases. Supported modes are single beep, N-beep burst and continuous alarm. It runs from the shared 0.5 ms tick strobe, accepts start/stop commands from the main control FSM, and reports busy and a one-cycle done pulse.

Parameters:
ON_TICKS, 200, length of one beep ON phase in tick strobes (>=2)
OFF_TICKS, 200, length of silent gap between beeps in tick strobes (>=1)
TONE_DIV, 1, tick strobes per tone half-period (1 = toggle every tick)
CNT_W, 4, width of beep-count input
TICK_W, 16, width of internal phase/tone counters (must hold ON_TICKS, OFF_TICKS, TONE_DIV)

Ports:
clk  input  1  system clock, 125 MHz
rstn  input  1  asynchronous active-low reset
tick  input  1  one-clock time-base strobe (0.5 ms)
buzStart  input  1  one-clock start command; latches buzMode/buzCount
buzStop  input  1  one-clock abort command
buzMode  input  2  00 single, 01 burst of buzCount beeps, 10 continuous, 11 treated as 00
buzCount  input  CNT_W  number of beeps for mode 01; 0 treated as 1
buzOut  output  1  tone output to buzzer driver
buzBusy  output  1  high while not IDLE
buzDone  output  1  one-clock pulse on normal pattern completion

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, port rstn.
- Reset values: state=IDLE, buzOut=0, buzBusy=0, buzDone=0, all counters 0.
- All outputs are registered.
- States:
  - IDLE, ON, OFF.
  - buzBusy = (state != IDLE).
- IDLE:
  - buzOut is held 0.
  - On buzStart, latch mode and beepsLeft on the same edge; next state ON; phaseCnt=0, toneCnt=0, buzOut=0.
  - beepsLeft = 1 for modes 00 and 11.
  - beepsLeft = max(buzCount, 1) for mode 01.
  - beepsLeft is don't-care for mode 10.
- ON: on each tick:
  - If phaseCnt == ON_TICKS-1 (end of phase): force buzOut=0, clear phaseCnt and toneCnt.
    - Mode 10: go to OFF.
    - Otherwise, if beepsLeft==1: go to IDLE and assert buzDone for exactly one clock on that edge.
    - Otherwise: decrement beepsLeft and go to OFF.
  - Else: phaseCnt++. If toneCnt == TONE_DIV-1, toggle buzOut and clear toneCnt; else toneCnt++.
- OFF:
  - buzOut is held 0.
  - On each tick, phaseCnt++.
  - On the tick where phaseCnt == OFF_TICKS-1: clear phaseCnt and toneCnt, go to ON.
- Non-tick cycles: counters and buzOut hold.
- buzStart while busy:
  - Restart from scratch: re-latch mode/count, state=ON, counters 0, buzOut=0.
  - No buzDone for the aborted pattern.
- buzStop (any state): next state IDLE, buzOut=0, counters cleared, no buzDone.
- buzStop and buzStart in the same cycle: stop wins, block goes IDLE.
- buzStop or buzStart coincident with a tick: the command takes priority over tick processing.
- Mode 10 runs until buzStop or buzStart and never pulses buzDone.
- Reset asserted mid-pattern: immediate return to reset values; buzOut drops asynchronously.
- Counter wrap: none is possible for legal parameters. beepsLeft never decrements below 1.

Test Plan:
1. Single beep. Setup: ON_TICKS=4, OFF_TICKS=2, TONE_DIV=1, tick every 4 clocks. Stimulus: buzStart with mode 00. Required response: buzOut=1 after tick1, 0 after tick2, 1 after tick3, 0 after tick4; buzDone one clock at the tick4 edge; buzBusy falls on the same edge.
2. Burst. Same parameters, mode 01, buzCount=3. Required response: three ON phases each showing the 1,0,1 pattern, separated by 2-tick silent gaps; one buzDone after the 3rd ON phase (12 ON ticks + 4 OFF ticks = 16 ticks after start).
3. Zero count. Mode 01, buzCount=0. Required response: behaves exactly like scenario 1.
4. Continuous then stop. Mode 10. Required response: ON/OFF alternates for at least 3 cycles. Then buzStop mid-ON with buzOut=1: buzOut=0 and buzBusy=0 the next clock; buzDone is never asserted.
5. Restart and simultaneous commands. buzStart (mode 01, count 2) at the 2nd tick of a running burst. Required response: phase restarts from phaseCnt=0 with 2 beeps total; no extra buzDone. Then buzStart and buzStop in the same cycle: block ends IDLE.
6. Slow tone and reset. TONE_DIV=2, ON_TICKS=6. Required response: buzOut toggles at ticks 2 and 4 only. Asserting rstn=0 mid-ON clears buzOut, buzBusy and buzDone immediately.
